// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-cycle controller.
// LCD register field layout, power-on init ROM and command classification.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } state_t;

  localparam int unsigned F_ON    = 31;
  localparam int unsigned F_RS    = 9;
  localparam int unsigned F_DB_HI = 7;
  localparam int unsigned F_DB_LO = 0;

  localparam int unsigned INIT_LEN = 6;

  // Entry 0 sits in the low byte: 38,38,38,0C,01,06.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
  };

  // Clear-display and return-home need the long execution wait.
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] db
  );
    return !rs && (db >= 8'h01) && (db <= 8'h03);
  endfunction

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_ctrl_timer.sv
// Loadable down-counter shared by every timed controller state.
// done is high while the count is 1, i.e. in the last cycle of a phase.
module lcd_ctrl_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] count;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      count <= i_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign o_done = (count == W'(1));

  // A zero load would never reach 1 and stall the controller.
  a_nonzero_load: assert property (
    @(posedge i_clk) i_load |-> (i_value != '0)
  );

endmodule

// File: rtl/lcd_ctrl.sv
// Turns LCD register writes into timed HD44780 write cycles.
// Runs the power-on init sequence and buffers one pending request.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned P_SETUP_CYC = 3,
  parameter int unsigned P_EN_CYC    = 13,
  parameter int unsigned P_HOLD_CYC  = 2,
  parameter int unsigned P_EXEC_CYC  = 2000,
  parameter int unsigned P_LONG_CYC  = 82000,
  parameter int unsigned P_PWRUP_CYC = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  input  logic        i_lcd_req,
  input  logic        i_clr_ovr,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_overrun
);

  localparam int unsigned P_MAX = max_u(
    max_u(max_u(P_SETUP_CYC, P_EN_CYC), max_u(P_HOLD_CYC, P_EXEC_CYC)),
    max_u(P_LONG_CYC, P_PWRUP_CYC)
  );
  localparam int unsigned TW = $clog2(P_MAX + 1);

  localparam logic [TW-1:0] T_SETUP = TW'(P_SETUP_CYC);
  localparam logic [TW-1:0] T_EN    = TW'(P_EN_CYC);
  localparam logic [TW-1:0] T_HOLD  = TW'(P_HOLD_CYC);
  localparam logic [TW-1:0] T_EXEC  = TW'(P_EXEC_CYC);
  localparam logic [TW-1:0] T_LONG  = TW'(P_LONG_CYC);
  localparam logic [TW-1:0] T_PWRUP = TW'(P_PWRUP_CYC);

  state_t        state;
  logic [2:0]    rom_idx;
  logic          buf_v;
  logic          buf_rs;
  logic [7:0]    buf_db;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;
  logic          pop;
  logic          push;

  logic unused_word;
  assign unused_word = ^{i_lcd_word[30:10], i_lcd_word[8]};

  assign pop  = (state == ST_IDLE) && buf_v;
  assign push = i_lcd_req && (!buf_v || pop);

  lcd_ctrl_timer #(
    .W (TW)
  ) u_timer (
    .i_clk   (i_clk),
    .i_load  (tmr_load),
    .i_value (tmr_value),
    .o_done  (tmr_done)
  );

  // Timer reload on entry to each timed state.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = T_PWRUP;
    if (i_reset) begin
      tmr_load = 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          tmr_load  = 1'b1;
          tmr_value = T_SETUP;
        end
        ST_IDLE: begin
          tmr_load  = buf_v;
          tmr_value = T_SETUP;
        end
        ST_SETUP: begin
          tmr_load  = tmr_done;
          tmr_value = T_EN;
        end
        ST_EN_HI: begin
          tmr_load  = tmr_done;
          tmr_value = T_HOLD;
        end
        ST_HOLD: begin
          tmr_load  = tmr_done;
          tmr_value = is_long_cmd(o_lcd_rs, o_lcd_data) ? T_LONG : T_EXEC;
        end
        default: ;
      endcase
    end
  end

  // Request buffer, panel power and sticky overrun flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_v     <= 1'b0;
      buf_rs    <= 1'b0;
      buf_db    <= '0;
      o_lcd_on  <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (push) begin
        buf_v    <= 1'b1;
        buf_rs   <= i_lcd_word[F_RS];
        buf_db   <= i_lcd_word[F_DB_HI:F_DB_LO];
        o_lcd_on <= i_lcd_word[F_ON];
      end else if (pop) begin
        buf_v <= 1'b0;
      end
      if (i_lcd_req && !push) begin
        o_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        o_overrun <= 1'b0;
      end
    end
  end

  // Write-cycle sequencer with registered bus outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_PWRUP;
      rom_idx     <= '0;
      o_lcd_en    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_data  <= '0;
      o_init_done <= 1'b0;
    end else begin
      case (state)
        ST_PWRUP: begin
          if (tmr_done) state <= ST_INIT;
        end
        ST_INIT: begin
          o_lcd_rs   <= 1'b0;
          o_lcd_data <= INIT_ROM[rom_idx];
          state      <= ST_SETUP;
        end
        ST_SETUP: begin
          if (tmr_done) begin
            o_lcd_en <= 1'b1;
            state    <= ST_EN_HI;
          end
        end
        ST_EN_HI: begin
          if (tmr_done) begin
            o_lcd_en <= 1'b0;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_done) state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (tmr_done) begin
            if (!o_init_done && rom_idx != 3'(INIT_LEN - 1)) begin
              rom_idx <= rom_idx + 3'd1;
              state   <= ST_INIT;
            end else begin
              o_init_done <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (buf_v) begin
            o_lcd_rs   <= buf_rs;
            o_lcd_data <= buf_db;
            state      <= ST_SETUP;
          end
        end
        default: state <= ST_PWRUP;
      endcase
    end
  end

  assign o_lcd_rw = 1'b0;
  assign o_busy   = (state != ST_IDLE) || buf_v;

endmodule
